// File: rtl/traffic_light_pkg.sv
// -----------------------------------------------------------------------------
// traffic_light_pkg
// Shared definitions for the multi-approach intersection controller.
//   phase_e      : phase encoding driven on the controller's phase output
//   DEF_*        : default timing / sizing constants used as parameter defaults
// -----------------------------------------------------------------------------
package traffic_light_pkg;

  typedef enum logic [1:0] {
    PH_ALLRED = 2'd0,
    PH_GREEN  = 2'd1,
    PH_YELLOW = 2'd2,
    PH_FLASH  = 2'd3
  } phase_e;

  localparam int DEF_NUM_DIRS = 2;
  localparam int DEF_TICK_DIV = 64;
  localparam int DEF_CNT_W    = 6;
  localparam int DEF_T_GREEN  = 20;
  localparam int DEF_T_YELLOW = 3;
  localparam int DEF_T_ALLRED = 2;

endpackage

// File: rtl/traffic_light_xing_tick_gen.sv
// -----------------------------------------------------------------------------
// tl_tick_gen
// Clock prescaler producing a one-cycle timing strobe every TICK_DIV enabled
// clocks. Holding en low freezes the count, so no strobe is lost or repeated.
// Ports:
//   clk  in  system clock
//   rst  in  asynchronous active-high reset
//   en   in  count enable
//   tick out one-cycle strobe, high while count == TICK_DIV-1 and en == 1
// -----------------------------------------------------------------------------
module tl_tick_gen #(
  parameter int TICK_DIV = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] count;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its inputs regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + PW'(1);
    end
  end

  assign tick = en && (count == LAST);

endmodule

// File: rtl/traffic_light_xing.sv
// -----------------------------------------------------------------------------
// traffic_light_xing
// Controller for NUM_DIRS conflicting approaches sharing one intersection.
// One approach owns green at a time; waiting approaches are served round-robin
// with a yellow and an all-red clearance between greens. All timing is counted
// in ticks from tl_tick_gen, so the whole block runs on clk alone.
//
// Optional build macro: NIGHT_FLASH_EN adds a FLASH phase (all yellows blink)
// entered at all-red expiry while night is high. Without it night is ignored.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   en         in   global run enable (low freezes prescaler, FSM, counter)
//   demand     in   per-approach request pulse, latched until served
//   night      in   night flash request (NIGHT_FLASH_EN builds only)
//   red        out  per-approach red lamp
//   yellow     out  per-approach yellow lamp
//   green      out  per-approach green lamp
//   active_dir out  approach owning green/yellow (last served during all-red)
//   phase      out  current phase (traffic_light_pkg::phase_e)
//   tick       out  one-cycle timing strobe
// -----------------------------------------------------------------------------
module traffic_light_xing
  import traffic_light_pkg::*;
#(
  parameter int NUM_DIRS = DEF_NUM_DIRS,
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int T_GREEN  = DEF_T_GREEN,
  parameter int T_YELLOW = DEF_T_YELLOW,
  parameter int T_ALLRED = DEF_T_ALLRED,
  localparam int DIR_W   = (NUM_DIRS > 2) ? $clog2(NUM_DIRS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [NUM_DIRS-1:0] demand,
  input  logic                night,
  output logic [NUM_DIRS-1:0] red,
  output logic [NUM_DIRS-1:0] yellow,
  output logic [NUM_DIRS-1:0] green,
  output logic [DIR_W-1:0]    active_dir,
  output phase_e              phase,
  output logic                tick
);

  localparam logic [CNT_W-1:0] LAST_GREEN  = CNT_W'(T_GREEN - 1);
  localparam logic [CNT_W-1:0] LAST_YELLOW = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] LAST_ALLRED = CNT_W'(T_ALLRED - 1);
  localparam logic [DIR_W-1:0] RESET_DIR   = DIR_W'(NUM_DIRS - 1);

  phase_e                phase_q, phase_d;
  logic [DIR_W-1:0]      dir_q, dir_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_DIRS-1:0]   dem_q, dem_d;
  logic [NUM_DIRS-1:0]   red_d, yellow_d, green_d;
  logic [NUM_DIRS-1:0]   own_mask, serve_mask, enter_mask;
  logic                  other_dem;
  logic                  green_entry;

`ifdef NIGHT_FLASH_EN
  logic flash_q, flash_d;
`else
  logic night_unused;
  assign night_unused = night;
`endif

  tl_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (tick)
  );

  // First approach after cur (wrapping, cur itself last) with a latched
  // request; with no requests anywhere, simply the next approach.
  function automatic logic [DIR_W-1:0] rr_next(input logic [DIR_W-1:0]    cur,
                                               input logic [NUM_DIRS-1:0] req);
    int   idx;
    logic found;
    rr_next = DIR_W'((int'(cur) + 1) % NUM_DIRS);
    found   = 1'b0;
    for (int k = 1; k <= NUM_DIRS; k++) begin
      idx = (int'(cur) + k) % NUM_DIRS;
      if (!found && req[idx[DIR_W-1:0]]) begin
        rr_next = idx[DIR_W-1:0];
        found   = 1'b1;
      end
    end
  endfunction

  assign own_mask  = NUM_DIRS'(1) << dir_q;
  assign other_dem = |(dem_q & ~own_mask);

  // ---------------------------------------------------------------------------
  // Phase FSM: next state. Everything advances only on tick, which is already
  // gated by en inside the prescaler.
  // ---------------------------------------------------------------------------
  always_comb begin : fsm_next
    // NOTE: every variable gets a default before any branch so no path leaves
    // it unassigned, which would otherwise infer a latch.
    phase_d = phase_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
`ifdef NIGHT_FLASH_EN
    flash_d = flash_q;
`endif
    if (tick) begin
      case (phase_q)
        PH_ALLRED: begin
          if (cnt_q == LAST_ALLRED) begin
            cnt_d = '0;
`ifdef NIGHT_FLASH_EN
            if (night) begin
              phase_d = PH_FLASH;
              flash_d = 1'b1;
            end else
`endif
            begin
              phase_d = PH_GREEN;
              dir_d   = rr_next(dir_q, dem_q);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        PH_GREEN: begin
          // Minimum green reached: the counter parks at its last value and
          // the phase rests until some other approach is waiting.
          if (cnt_q == LAST_GREEN) begin
            if (other_dem) begin
              phase_d = PH_YELLOW;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        PH_YELLOW: begin
          if (cnt_q == LAST_YELLOW) begin
            phase_d = PH_ALLRED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
`ifdef NIGHT_FLASH_EN
          if (!night) begin
            phase_d = PH_ALLRED;
            cnt_d   = '0;
          end else begin
            flash_d = ~flash_q;
          end
`else
          phase_d = PH_ALLRED;
          cnt_d   = '0;
`endif
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Demand latches: requests from the approach currently being served are
  // dropped, and the latch of an approach entering green is cleared (clearing
  // takes priority over a simultaneous request).
  // ---------------------------------------------------------------------------
  assign green_entry = (phase_d == PH_GREEN) && (phase_q != PH_GREEN);

  always_comb begin : demand_next
    serve_mask = '0;
    enter_mask = '0;
    if (phase_q == PH_GREEN || phase_q == PH_YELLOW) serve_mask = own_mask;
    if (green_entry) enter_mask = NUM_DIRS'(1) << dir_d;
    dem_d = (dem_q | (demand & ~serve_mask)) & ~enter_mask;
  end

  // ---------------------------------------------------------------------------
  // Lamps decoded from the next state and registered alongside it, so lamp
  // changes line up with the phase output on the same edge.
  // ---------------------------------------------------------------------------
  always_comb begin : lamp_next
    red_d    = '1;
    yellow_d = '0;
    green_d  = '0;
    case (phase_d)
      PH_GREEN: begin
        green_d = NUM_DIRS'(1) << dir_d;
        red_d   = ~green_d;
      end
      PH_YELLOW: begin
        yellow_d = NUM_DIRS'(1) << dir_d;
        red_d    = ~yellow_d;
      end
`ifdef NIGHT_FLASH_EN
      PH_FLASH: begin
        red_d    = '0;
        yellow_d = {NUM_DIRS{flash_d}};
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= PH_ALLRED;
      dir_q   <= RESET_DIR;
      cnt_q   <= '0;
      dem_q   <= '0;
      red     <= '1;
      yellow  <= '0;
      green   <= '0;
    end else begin
      phase_q <= phase_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      dem_q   <= dem_d;
      red     <= red_d;
      yellow  <= yellow_d;
      green   <= green_d;
    end
  end

`ifdef NIGHT_FLASH_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) flash_q <= 1'b0;
    else     flash_q <= flash_d;
  end
`endif

  assign phase      = phase_q;
  assign active_dir = dir_q;

endmodule

// File: tb/tb_traffic_light_xing.sv
// -----------------------------------------------------------------------------
// tb_traffic_light_xing
// Directed bench for traffic_light_xing with TICK_DIV=4, T_GREEN=5,
// T_YELLOW=2, T_ALLRED=1: a 2-approach instance and a 4-approach instance.
// Inputs change and outputs are sampled on the falling clock edge; k counts
// rising edges since reset release. The night-flash scenario is built when
// NIGHT_FLASH_EN is defined; otherwise night is checked to have no effect.
// -----------------------------------------------------------------------------
module tb_traffic_light_xing;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // 2-approach instance
  logic       rst2 = 1'b1, en2 = 1'b1, night2 = 1'b0;
  logic [1:0] demand2 = '0, red2, yellow2, green2, phase2;
  logic       dir2, tick2;

  // 4-approach instance
  logic       rst4 = 1'b1, en4 = 1'b1, night4 = 1'b0;
  logic [3:0] demand4 = '0, red4, yellow4, green4;
  logic [1:0] dir4, phase4;
  logic       tick4;

  traffic_light_xing #(
    .NUM_DIRS(2), .TICK_DIV(4), .CNT_W(6), .T_GREEN(5), .T_YELLOW(2), .T_ALLRED(1)
  ) dut2 (
    .clk(clk), .rst(rst2), .en(en2), .demand(demand2), .night(night2),
    .red(red2), .yellow(yellow2), .green(green2), .active_dir(dir2),
    .phase(phase2), .tick(tick2)
  );

  traffic_light_xing #(
    .NUM_DIRS(4), .TICK_DIV(4), .CNT_W(6), .T_GREEN(5), .T_YELLOW(2), .T_ALLRED(1)
  ) dut4 (
    .clk(clk), .rst(rst4), .en(en4), .demand(demand4), .night(night4),
    .red(red4), .yellow(yellow4), .green(green4), .active_dir(dir4),
    .phase(phase4), .tick(tick4)
  );

  // Reference lamp pattern {red, yellow, green} (4 bits each) for a phase,
  // active approach, approach count and flash level.
  function automatic logic [11:0] lamps(input logic [1:0] ph, input int dir,
                                        input int n, input logic fl);
    logic [3:0] r, y, g, m;
    m = (n == 2) ? 4'b0011 : 4'b1111;
    y = 4'b0000;
    g = 4'b0000;
    if (ph == 2'd1)      g = 4'b0001 << dir;
    else if (ph == 2'd2) y = 4'b0001 << dir;
    else if (ph == 2'd3) y = m & {4{fl}};
    r = (ph == 2'd3) ? 4'b0000 : (m & ~(y | g));
    return {r, y, g};
  endfunction

  function automatic logic [9:0] exp2(input logic [1:0] ph, input int dir,
                                      input logic fl, input logic tk);
    logic [11:0] l;
    l = lamps(ph, dir, 2, fl);
    return {ph, 1'(dir), l[9:8], l[5:4], l[1:0], tk};
  endfunction

  task automatic release2();
    rst2 = 1'b1; en2 = 1'b1; demand2 = '0;
    @(negedge clk);
    @(negedge clk);
    rst2 = 1'b0;
  endtask

  // Reset values on both instances while reset is held.
  task automatic test_reset();
    logic [9:0]  got2;
    logic [16:0] got4;
    repeat (2) @(negedge clk);
    got2 = {phase2, dir2, red2, yellow2, green2, tick2};
    n_checks++;
    if (got2 !== 10'b00_1_11_00_00_0) begin
      $display("FAIL reset2 got=%b exp=%b", got2, 10'b00_1_11_00_00_0);
      n_fail++;
    end
    got4 = {phase4, dir4, red4, yellow4, green4, tick4};
    n_checks++;
    if (got4 !== 17'b00_11_1111_0000_0000_0) begin
      $display("FAIL reset4 got=%b exp=%b", got4, 17'b00_11_1111_0000_0000_0);
      n_fail++;
    end
  endtask

  // Scenario 1: no demand; dir0 takes green after 4 clocks and rests there.
  // An own-approach request during that green must be ignored.
  task automatic test_rest();
    logic [9:0] got, exp;
    rst2 = 1'b0;
    for (int k = 1; k <= 28; k++) begin
      @(negedge clk);
      got = {phase2, dir2, red2, yellow2, green2, tick2};
      exp = (k < 4) ? exp2(2'd0, 1, 1'b0, k % 4 == 3) : exp2(2'd1, 0, 1'b0, k % 4 == 3);
      n_checks++;
      if (got !== exp) begin
        $display("FAIL rest k=%0d got=%b exp=%b", k, got, exp);
        n_fail++;
      end
      demand2 = (k == 9) ? 2'b01 : 2'b00;
    end
    n_checks++;
    if (dut2.dem_q !== 2'b00) begin
      $display("FAIL rest_own_demand got=%b exp=%b", dut2.dem_q, 2'b00);
      n_fail++;
    end
  endtask

  // Scenario 2: demand[1] during resting green -> yellow 8 clks, all-red 4,
  // green[1], latch cleared.
  task automatic test_yield();
    logic [9:0] got, exp;
    logic [1:0] ph;
    int         dir;
    demand2 = 2'b10;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      demand2 = 2'b00;
      if (c <= 3)       begin ph = 2'd1; dir = 0; end
      else if (c <= 11) begin ph = 2'd2; dir = 0; end
      else if (c <= 15) begin ph = 2'd0; dir = 0; end
      else              begin ph = 2'd1; dir = 1; end
      got = {phase2, dir2, red2, yellow2, green2, tick2};
      exp = exp2(ph, dir, 1'b0, (28 + c) % 4 == 3);
      n_checks++;
      if (got !== exp) begin
        $display("FAIL yield c=%0d got=%b exp=%b", c, got, exp);
        n_fail++;
      end
    end
    n_checks++;
    if (dut2.dem_q !== 2'b00) begin
      $display("FAIL yield_latch_clear got=%b exp=%b", dut2.dem_q, 2'b00);
      n_fail++;
    end
  endtask

  // Scenario 4: en low for 10 clocks mid-yellow; the timeline resumes
  // exactly, shifted by the pause (e = enabled-edge count).
  task automatic test_enable_hold();
    logic [9:0] got, exp;
    logic [1:0] ph;
    int         dir, e;
    int         yellow_cnt;
    logic       en_now;
    yellow_cnt = 0;
    release2();
    for (int k = 1; k <= 46; k++) begin
      @(negedge clk);
      en_now = en2;
      e = (k <= 26) ? k : ((k <= 36) ? 26 : k - 10);
      if (e <= 3)       begin ph = 2'd0; dir = 1; end
      else if (e <= 23) begin ph = 2'd1; dir = 0; end
      else if (e <= 31) begin ph = 2'd2; dir = 0; end
      else if (e <= 35) begin ph = 2'd0; dir = 0; end
      else              begin ph = 2'd1; dir = 1; end
      got = {phase2, dir2, red2, yellow2, green2, tick2};
      exp = exp2(ph, dir, 1'b0, en_now && (e % 4 == 3));
      n_checks++;
      if (got !== exp) begin
        $display("FAIL enable_hold k=%0d got=%b exp=%b", k, got, exp);
        n_fail++;
      end
      if (yellow2[0]) yellow_cnt++;
      demand2 = (k == 4) ? 2'b10 : 2'b00;
      en2     = !((k + 1) >= 27 && (k + 1) <= 36);
    end
    n_checks++;
    if (yellow_cnt != 18) begin
      $display("FAIL enable_yellow_len got=%0d exp=%0d", yellow_cnt, 18);
      n_fail++;
    end
  endtask

  // Scenario 5: rst raised between edges during green[1] with a pending
  // request; outputs and latches must clear before the next edge.
  task automatic test_async_reset();
    logic [9:0] got;
    demand2 = 2'b01;
    @(negedge clk);
    demand2 = 2'b00;
    n_checks++;
    if (green2 !== 2'b10 || dut2.dem_q !== 2'b01) begin
      $display("FAIL async_pre green=%b latch=%b exp green=10 latch=01", green2, dut2.dem_q);
      n_fail++;
    end
    @(posedge clk);
    #3 rst2 = 1'b1;
    #1;
    got = {phase2, dir2, red2, yellow2, green2, tick2};
    n_checks++;
    if (got !== 10'b00_1_11_00_00_0) begin
      $display("FAIL async_reset got=%b exp=%b", got, 10'b00_1_11_00_00_0);
      n_fail++;
    end
    n_checks++;
    if (dut2.dem_q !== 2'b00) begin
      $display("FAIL async_latch got=%b exp=%b", dut2.dem_q, 2'b00);
      n_fail++;
    end
    @(negedge clk);
    rst2 = 1'b0;
  endtask

  // Scenario 3: 4 approaches, requests on 3 and 2 during green0 -> dir2 is
  // served next (dir1 skipped), then dir3.
  task automatic test_round_robin();
    logic [16:0] got, exp;
    logic [11:0] l;
    logic [1:0]  ph;
    int          dir;
    @(negedge clk);
    rst4 = 1'b0;
    for (int k = 1; k <= 72; k++) begin
      @(negedge clk);
      if (k <= 3)       begin ph = 2'd0; dir = 3; end
      else if (k <= 23) begin ph = 2'd1; dir = 0; end
      else if (k <= 31) begin ph = 2'd2; dir = 0; end
      else if (k <= 35) begin ph = 2'd0; dir = 0; end
      else if (k <= 55) begin ph = 2'd1; dir = 2; end
      else if (k <= 63) begin ph = 2'd2; dir = 2; end
      else if (k <= 67) begin ph = 2'd0; dir = 2; end
      else              begin ph = 2'd1; dir = 3; end
      l   = lamps(ph, dir, 4, 1'b0);
      got = {phase4, dir4, red4, yellow4, green4, tick4};
      exp = {ph, 2'(dir), l, (k % 4 == 3)};
      n_checks++;
      if (got !== exp) begin
        $display("FAIL round_robin k=%0d got=%b exp=%b", k, got, exp);
        n_fail++;
      end
      demand4 = (k == 4) ? 4'b1100 : 4'b0000;
    end
  endtask

`ifdef NIGHT_FLASH_EN
  // Scenario 6: night from reset -> FLASH at first all-red expiry, yellows
  // toggle per tick; a request captured during FLASH steers the selection
  // after night drops and the full all-red has run.
  task automatic test_night_flash();
    logic [9:0] got, exp;
    logic [1:0] ph;
    int         dir;
    logic       fl;
    night2 = 1'b1;
    release2();
    for (int k = 1; k <= 28; k++) begin
      @(negedge clk);
      fl = 1'b0;
      if (k <= 3)       begin ph = 2'd0; dir = 1; end
      else if (k <= 19) begin ph = 2'd3; dir = 1; fl = (((k - 4) / 4) % 2 == 0); end
      else if (k <= 23) begin ph = 2'd0; dir = 1; end
      else              begin ph = 2'd1; dir = 1; end
      got = {phase2, dir2, red2, yellow2, green2, tick2};
      exp = exp2(ph, dir, fl, k % 4 == 3);
      n_checks++;
      if (got !== exp) begin
        $display("FAIL night_flash k=%0d got=%b exp=%b", k, got, exp);
        n_fail++;
      end
      demand2 = (k == 9) ? 2'b10 : 2'b00;
      night2  = ((k + 1) >= 18) ? 1'b0 : 1'b1;
    end
    n_checks++;
    if (dut2.dem_q !== 2'b00) begin
      $display("FAIL night_latch got=%b exp=%b", dut2.dem_q, 2'b00);
      n_fail++;
    end
  endtask
`else
  // Without the flash build night must not alter the normal sequence.
  task automatic test_night_ignored();
    logic [9:0] got, exp;
    night2 = 1'b1;
    release2();
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      got = {phase2, dir2, red2, yellow2, green2, tick2};
      exp = (k < 4) ? exp2(2'd0, 1, 1'b0, k % 4 == 3) : exp2(2'd1, 0, 1'b0, k % 4 == 3);
      n_checks++;
      if (got !== exp) begin
        $display("FAIL night_ignored k=%0d got=%b exp=%b", k, got, exp);
        n_fail++;
      end
    end
    night2 = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_rest();
    test_yield();
    test_enable_hold();
    test_async_reset();
    test_round_robin();
`ifdef NIGHT_FLASH_EN
    test_night_flash();
`else
    test_night_ignored();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
